muldiv_decode_seq: RTL and testbench

Decode-stage control unit for the pipelined RISC-V core. It is the successor to the single-cycle combinational main decoder and adds M-extension (MUL/DIV) support. Multi-cycle operations are sequenced by a small FSM that holds the instruction in Decode, requests stalls from the hazard unit, and releases the register write only on the final cycle. The block sits between the F/D pipeline register and the D/E register, alongside the ALU decoder.

---
 rtl/core_ctrl_pkg.sv | 55 +++++
 rtl/base_opdecode.sv | 80 ++++++++
 rtl/muldiv_decode_seq.sv | 167 ++++++++++++++++
 tb/tb_muldiv_decode_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared decode-stage definitions: opcodes, control-field encodings,
// the mul/div sequencer state type and the control bundle.
package core_ctrl_pkg;

    localparam logic [6:0] OP_BUBBLE = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;
    localparam logic [2:0] RES_IMM = 3'b011;
    localparam logic [2:0] RES_CSR = 3'b100;
    localparam logic [2:0] RES_MD  = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic {IDLE, WAIT} md_state_t;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic       jumpALR;
        logic [2:0] immSrc;
        logic [2:0] resultSrc;
        logic [1:0] aluOp;
        logic       usesRs1;
        logic       usesRs2;
        logic       mulDiv;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/base_opdecode.sv
// Combinational base-ISA main decoder: opcode to pipeline controls.
// Unknown opcodes produce all-zero controls with the illegal flag set.
module base_opdecode
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (op)
            OP_BUBBLE: ;
            OP_LOAD: begin
                ctrl.regWrite  = 1'b1;
                ctrl.aluSrc    = 1'b1;
                ctrl.immSrc    = IMM_I;
                ctrl.resultSrc = RES_MEM;
                ctrl.usesRs1   = 1'b1;
            end
            OP_STORE: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.immSrc   = IMM_S;
                ctrl.usesRs1  = 1'b1;
                ctrl.usesRs2  = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALUOP_FUNCT;
                ctrl.usesRs1  = 1'b1;
                ctrl.usesRs2  = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.immSrc  = IMM_B;
                ctrl.aluOp   = ALUOP_BR;
                ctrl.usesRs1 = 1'b1;
                ctrl.usesRs2 = 1'b1;
            end
            OP_IALU: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.immSrc   = IMM_I;
                ctrl.aluOp    = ALUOP_FUNCT;
                ctrl.usesRs1  = 1'b1;
            end
            OP_JAL: begin
                ctrl.regWrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.immSrc    = IMM_J;
                ctrl.resultSrc = RES_PC4;
            end
            OP_JALR: begin
                ctrl.regWrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jumpALR   = 1'b1;
                ctrl.aluSrc    = 1'b1;
                ctrl.immSrc    = IMM_I;
                ctrl.resultSrc = RES_PC4;
                ctrl.usesRs1   = 1'b1;
            end
            OP_AUIPC, OP_LUI: begin
                ctrl.regWrite  = 1'b1;
                ctrl.immSrc    = IMM_U;
                ctrl.resultSrc = RES_IMM;
            end
            OP_CSR: begin
                ctrl.regWrite  = 1'b1;
                ctrl.immSrc    = IMM_I;
                ctrl.resultSrc = RES_CSR;
                ctrl.usesRs1   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/muldiv_decode_seq.sv
// Decode-stage control with M-extension overlay; a two-state sequencer holds
// multi-cycle mul/div ops in Decode and releases RegWrite on the final cycle.
module muldiv_decode_seq
    import core_ctrl_pkg::*;
#(
    parameter bit          M_EXT       = 1'b1,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 32
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrD,
    input  logic        stallD,
    input  logic        flushD,
    output logic        RegWriteD,
    output logic        MemWriteD,
    output logic        ALUSrcD,
    output logic        BranchD,
    output logic        JumpD,
    output logic        JumpALRD,
    output logic [2:0]  immsrcD,
    output logic [2:0]  ResultSrcD,
    output logic [1:0]  ALUOp,
    output logic        UsesRs1D,
    output logic        UsesRs2D,
    output logic        MulDivD,
    output logic        mdStartD,
    output logic        busyD,
    output logic        illegalD
);

    localparam int unsigned MAX_LAT   = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int unsigned CNT_W     = $clog2(MAX_LAT + 1);
    localparam bit          MUL_MULTI = (MUL_LATENCY > 1);
    localparam bit          DIV_MULTI = (DIV_LATENCY > 1);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       isDiv;
    logic       isMulDivOp;
    logic       mExtOp;
    logic       unusedInstr;

    assign opcode      = instrD[6:0];
    assign funct7      = instrD[31:25];
    assign isDiv       = instrD[14];
    assign isMulDivOp  = (opcode == OP_RTYPE) && (funct7 == FUNCT7_MULDIV);
    assign mExtOp      = M_EXT && isMulDivOp;
    assign unusedInstr = ^{instrD[24:15], instrD[13:7]};

    ctrl_t baseCtrl;
    logic  baseIllegal;

    base_opdecode uBase (
        .op      (opcode),
        .ctrl    (baseCtrl),
        .illegal (baseIllegal)
    );

    // M-extension overlay on top of the base decode
    ctrl_t mdCtrl;
    ctrl_t decCtrl;
    logic  decIllegal;

    always_comb begin
        mdCtrl           = CTRL_NOP;
        mdCtrl.regWrite  = 1'b1;
        mdCtrl.resultSrc = RES_MD;
        mdCtrl.usesRs1   = 1'b1;
        mdCtrl.usesRs2   = 1'b1;
        mdCtrl.mulDiv    = 1'b1;

        decCtrl    = baseCtrl;
        decIllegal = baseIllegal;
        if (isMulDivOp) begin
            if (M_EXT) begin
                decCtrl = mdCtrl;
            end else begin
                decCtrl    = CTRL_NOP;
                decIllegal = 1'b1;
            end
        end
    end

    md_state_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext, cntDec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    ctrl_t ctrlOut;
    logic  illegalOut;
    logic  startOut;
    logic  busyOut;

    // Sequencer next state and output masking; RegWrite only on release
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        ctrlOut    = decCtrl;
        illegalOut = decIllegal;
        startOut   = 1'b0;
        busyOut    = 1'b0;
        cntDec     = cnt - CNT_W'(1);

        if (flushD) begin
            stateNext  = IDLE;
            cntNext    = '0;
            ctrlOut    = CTRL_NOP;
            illegalOut = 1'b0;
        end else if (state == IDLE) begin
            if (mExtOp) begin
                ctrlOut.regWrite = 1'b0;
                if (!stallD && !reset) begin
                    startOut = 1'b1;
                    if (isDiv ? DIV_MULTI : MUL_MULTI) begin
                        busyOut   = 1'b1;
                        stateNext = WAIT;
                        cntNext   = isDiv ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
                    end else begin
                        ctrlOut.regWrite = 1'b1;
                    end
                end
            end
        end else begin
            // Instruction is held in Decode; present it as a mul/div op
            ctrlOut          = mdCtrl;
            ctrlOut.regWrite = 1'b0;
            illegalOut       = 1'b0;
            if (stallD) begin
                busyOut = 1'b1;
            end else if (cntDec != '0) begin
                busyOut = 1'b1;
                cntNext = cntDec;
            end else begin
                ctrlOut.regWrite = 1'b1;
                stateNext        = IDLE;
                cntNext          = '0;
            end
        end
    end

    assign RegWriteD  = ctrlOut.regWrite;
    assign MemWriteD  = ctrlOut.memWrite;
    assign ALUSrcD    = ctrlOut.aluSrc;
    assign BranchD    = ctrlOut.branch;
    assign JumpD      = ctrlOut.jump;
    assign JumpALRD   = ctrlOut.jumpALR;
    assign immsrcD    = ctrlOut.immSrc;
    assign ResultSrcD = ctrlOut.resultSrc;
    assign ALUOp      = ctrlOut.aluOp;
    assign UsesRs1D   = ctrlOut.usesRs1;
    assign UsesRs2D   = ctrlOut.usesRs2;
    assign MulDivD    = ctrlOut.mulDiv;
    assign mdStartD   = startOut;
    assign busyD      = busyOut;
    assign illegalD   = illegalOut;

endmodule

// File: tb/tb_muldiv_decode_seq.sv
// Scoreboard bench: the driver queues hand-computed expected outputs for an
// M-enabled instance and an M_EXT=0 instance; a monitor checks them each cycle.
module tb_muldiv_decode_seq;

    // Packed order: RegWrite MemWrite ALUSrc Branch Jump JumpALR imm[3] res[3]
    //               ALUOp[2] UsesRs1 UsesRs2 MulDiv mdStart busy illegal
    localparam logic [19:0] V_ZERO  = 20'b0;
    localparam logic [19:0] V_ILL   = 20'b1;
    localparam logic [19:0] V_LW    = {6'b101000, 3'b000, 3'b001, 2'b00, 2'b10, 4'b0000};
    localparam logic [19:0] V_ADD   = {6'b100000, 3'b000, 3'b000, 2'b10, 2'b11, 4'b0000};
    localparam logic [19:0] V_SW    = {6'b011000, 3'b001, 3'b000, 2'b00, 2'b11, 4'b0000};
    localparam logic [19:0] V_BEQ   = {6'b000100, 3'b010, 3'b000, 2'b01, 2'b11, 4'b0000};
    localparam logic [19:0] V_JAL   = {6'b100010, 3'b011, 3'b010, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] V_MACC  = {6'b000000, 3'b000, 3'b101, 2'b00, 2'b11, 4'b1110};
    localparam logic [19:0] V_MPEND = {6'b000000, 3'b000, 3'b101, 2'b00, 2'b11, 4'b1010};
    localparam logic [19:0] V_MREL  = {6'b100000, 3'b000, 3'b101, 2'b00, 2'b11, 4'b1000};
    localparam logic [19:0] V_MHOLD = {6'b000000, 3'b000, 3'b101, 2'b00, 2'b11, 4'b1000};

    localparam logic [31:0] I_LW  = 32'h00012083;
    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SW  = 32'h00112023;
    localparam logic [31:0] I_BEQ = 32'h00208063;
    localparam logic [31:0] I_JAL = 32'h008000EF;
    localparam logic [31:0] I_MUL = 32'h022081B3;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    typedef struct {
        logic [19:0] e;
        logic [19:0] e0;
        string       name;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrD;
    logic        stallD;
    logic        flushD;

    logic        rw, mw, as, br, jp, jr, u1, u2, md, st, bz, il;
    logic [2:0]  imm, rs;
    logic [1:0]  aop;
    logic        rw0, mw0, as0, br0, jp0, jr0, u10, u20, md0, st0, bz0, il0;
    logic [2:0]  imm0, rs0;
    logic [1:0]  aop0;

    always #5 clk = ~clk;

    muldiv_decode_seq dut (
        .clk(clk), .reset(reset), .instrD(instrD), .stallD(stallD), .flushD(flushD),
        .RegWriteD(rw), .MemWriteD(mw), .ALUSrcD(as), .BranchD(br), .JumpD(jp),
        .JumpALRD(jr), .immsrcD(imm), .ResultSrcD(rs), .ALUOp(aop),
        .UsesRs1D(u1), .UsesRs2D(u2), .MulDivD(md), .mdStartD(st), .busyD(bz),
        .illegalD(il)
    );

    muldiv_decode_seq #(.M_EXT(1'b0)) dutNoM (
        .clk(clk), .reset(reset), .instrD(instrD), .stallD(stallD), .flushD(flushD),
        .RegWriteD(rw0), .MemWriteD(mw0), .ALUSrcD(as0), .BranchD(br0), .JumpD(jp0),
        .JumpALRD(jr0), .immsrcD(imm0), .ResultSrcD(rs0), .ALUOp(aop0),
        .UsesRs1D(u10), .UsesRs2D(u20), .MulDivD(md0), .mdStartD(st0), .busyD(bz0),
        .illegalD(il0)
    );

    logic [19:0] act, act0;
    assign act  = {rw, mw, as, br, jp, jr, imm, rs, aop, u1, u2, md, st, bz, il};
    assign act0 = {rw0, mw0, as0, br0, jp0, jr0, imm0, rs0, aop0, u10, u20, md0, st0, bz0, il0};

    // Monitor: one expected entry per presented cycle, checked mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t it;
            it = q.pop_front();
            compared++;
            if (act !== it.e) begin
                mismatched++;
                $display("FAIL %s (M_EXT=1): got %b required %b", it.name, act, it.e);
            end
            compared++;
            if (act0 !== it.e0) begin
                mismatched++;
                $display("FAIL %s (M_EXT=0): got %b required %b", it.name, act0, it.e0);
            end
        end
    end

    task automatic step(input logic [31:0] instr, input logic rst, input logic stall,
                        input logic flush, input logic [19:0] e, input logic [19:0] e0,
                        input string name);
        exp_t it;
        @(posedge clk);
        #1;
        instrD = instr;
        reset  = rst;
        stallD = stall;
        flushD = flush;
        it.e    = e;
        it.e0   = e0;
        it.name = name;
        q.push_back(it);
    endtask

    initial begin
        reset  = 1'b1;
        instrD = '0;
        stallD = 1'b0;
        flushD = 1'b0;

        step('0, 1'b1, 1'b0, 1'b0, V_ZERO, V_ZERO, "reset bubble");
        step('0, 1'b0, 1'b0, 1'b0, V_ZERO, V_ZERO, "bubble");
        step(I_LW,  1'b0, 1'b0, 1'b0, V_LW,  V_LW,  "lw");
        step(I_ADD, 1'b0, 1'b0, 1'b0, V_ADD, V_ADD, "add");
        step(I_SW,  1'b0, 1'b0, 1'b0, V_SW,  V_SW,  "sw");
        step(I_BEQ, 1'b0, 1'b0, 1'b0, V_BEQ, V_BEQ, "beq");
        step(I_JAL, 1'b0, 1'b0, 1'b0, V_JAL, V_JAL, "jal");
        step(I_BAD, 1'b0, 1'b0, 1'b0, V_ILL, V_ILL, "opcode 1111111");

        // MUL, latency 2
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MACC, V_ILL, "mul c0");
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MREL, V_ILL, "mul c1");
        step(I_LW,  1'b0, 1'b0, 1'b0, V_LW,   V_LW,  "lw after mul");

        // DIV, latency 32: busy on cycles 0..30, release on 31
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MACC, V_ILL, "div c0");
        for (int i = 1; i < 31; i++)
            step(I_DIV, 1'b0, 1'b0, 1'b0, V_MPEND, V_ILL, $sformatf("div c%0d", i));
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MREL, V_ILL, "div c31");
        step(I_ADD, 1'b0, 1'b0, 1'b0, V_ADD,  V_ADD, "add after div");

        // DIV with a 3-cycle stall in the middle: 35 cycles total
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MACC, V_ILL, "sdiv c0");
        for (int i = 1; i < 10; i++)
            step(I_DIV, 1'b0, 1'b0, 1'b0, V_MPEND, V_ILL, $sformatf("sdiv c%0d", i));
        for (int i = 10; i < 13; i++)
            step(I_DIV, 1'b0, 1'b1, 1'b0, V_MPEND, V_ILL, $sformatf("sdiv stall c%0d", i));
        for (int i = 13; i < 34; i++)
            step(I_DIV, 1'b0, 1'b0, 1'b0, V_MPEND, V_ILL, $sformatf("sdiv c%0d", i));
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MREL, V_ILL, "sdiv c34");

        // Stall landing on the release cycle defers it
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MACC,  V_ILL, "smul c0");
        step(I_MUL, 1'b0, 1'b1, 1'b0, V_MPEND, V_ILL, "smul stalled release");
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MREL,  V_ILL, "smul release");

        // DIV flushed at cycle 10
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MACC, V_ILL, "fdiv c0");
        for (int i = 1; i < 10; i++)
            step(I_DIV, 1'b0, 1'b0, 1'b0, V_MPEND, V_ILL, $sformatf("fdiv c%0d", i));
        step(I_DIV, 1'b0, 1'b0, 1'b1, V_ZERO, V_ZERO, "fdiv flush");
        step(I_LW,  1'b0, 1'b0, 1'b0, V_LW,   V_LW,   "lw after flush");

        // Flush and accept in the same cycle
        step(I_MUL, 1'b0, 1'b0, 1'b1, V_ZERO, V_ZERO, "mul flushed at accept");
        step(I_LW,  1'b0, 1'b0, 1'b0, V_LW,   V_LW,   "lw after flushed accept");

        // Reset mid-sequence: back to IDLE with no RegWrite pulse
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MACC,  V_ILL, "rdiv c0");
        step(I_DIV, 1'b0, 1'b0, 1'b0, V_MPEND, V_ILL, "rdiv c1");
        step(I_DIV, 1'b1, 1'b0, 1'b0, V_MHOLD, V_ILL, "rdiv reset");
        step(I_LW,  1'b0, 1'b0, 1'b0, V_LW,    V_LW,  "lw after reset");
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MACC,  V_ILL, "mul after reset c0");
        step(I_MUL, 1'b0, 1'b0, 1'b0, V_MREL,  V_ILL, "mul after reset c1");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
